fb_byte_writer: RTL and testbench
=================================

Name: fb_byte_writer

Overview:
- Upstream write-side feeder for the dual-width frame-buffer RAM (8-bit write port, 12-bit byte address; 16-bit read port, 11-bit word address).
- Parses a byte command stream from the UART receiver and drives the RAM write port: address, data and write strobe.
- Supports two commands: full-frame load from address 0, and an addressed patch burst.
- One write per accepted byte; the RAM needs no backpressure, so flow control only honours a display-side lock.

Parameters:
- ADDR_W, 12, RAM byte-address width.
- FRAME_BYTES, 4096, bytes per full-frame load (must be ≤ 2**ADDR_W).
- CMD_LOAD, 8'h4C, opcode for a full-frame load.
- CMD_PATCH, 8'h50, opcode for a patch burst.
- TIMEOUT_CYCLES, 1000000, idle cycles before a mid-command abort (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  block accepts a byte this cycle.
- mem_lock  in  1  display holds the buffer; no bytes are accepted while high.
- wr_addr  out  ADDR_W  RAM byte address, to AddressA.
- wr_data  out  8  RAM write data, to DataInA.
- wr_en  out  1  RAM write strobe, to WrA (ClockEnA is tied high at the top level).
- busy  out  1  a command is in progress.
- frame_done  out  1  one-cycle pulse when a load or patch completes.
- err  out  1  one-cycle pulse on an abort (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; wr_addr=0, wr_data=0, wr_en=0, busy=0, frame_done=0, err=0, rx_ready=0. All internal counters are 0.
- Handshake:
  - rx_ready = reset_n released AND !mem_lock.
  - A byte is accepted when rx_valid & rx_ready.
  - rx_data is don't-care while rx_valid=0.
- State IDLE:
  - Accepted CMD_LOAD → L_DATA; addr counter = 0; byte counter = 0.
  - Accepted CMD_PATCH → P_AHI.
  - Any other byte is dropped silently and the state stays IDLE.
- State P_AHI: accepted byte[3:0] → addr[11:8]; upper nibble ignored → P_ALO.
- State P_ALO: accepted byte → addr[7:0] → P_CNT.
- State P_CNT: accepted byte n → remaining = n+1 (range 1..256) → P_DATA.
- Data states (L_DATA and P_DATA), per accepted byte:
  - Register wr_data = byte, wr_addr = addr, and pulse wr_en for exactly one cycle.
  - Write latency: the byte accepted in cycle N appears on wr_en/wr_addr/wr_data in cycle N+1.
  - Then increment addr modulo 2**ADDR_W; 4095 wraps to 0 within a patch.
- L_DATA completes after FRAME_BYTES accepted bytes; P_DATA completes when remaining reaches 0.
  - On completion, frame_done pulses in the same cycle as the last wr_en, and the state returns to IDLE.
- busy is 1 in every state except IDLE. It drops the cycle after the final byte is accepted.
- wr_en=0 whenever no byte was accepted in the prior cycle, including every cycle mem_lock is high. Gaps in rx_valid simply stall progress.
- mem_lock rising mid-command: the command is paused, not aborted; the addr counter and remaining count are held.
- Byte mapping in the RAM:
  - Even byte address → upper half of the 16-bit read word (QB[15:8]).
  - Odd byte address → QB[7:0].
  - Read word address = byte address >> 1.
- Opcode values arriving in a data state are treated as data, not as commands.
- Reset mid-command returns to IDLE at once. No partial-write cleanup is performed.

Optional Feature:
- Macro: FB_WRITER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on every accepted byte and on entry to IDLE, and counts while state≠IDLE.
  - At TIMEOUT_CYCLES the block aborts to IDLE and pulses err for one cycle; no wr_en and no frame_done are issued that cycle.
  - mem_lock high freezes the counter.
- Without the macro: no counter exists, err is tied 0, and a stalled command waits forever.

Decomposition:
- Package fb_writer_pkg:
  - state enum: IDLE, P_AHI, P_ALO, P_CNT, P_DATA, L_DATA.
  - CMD_LOAD and CMD_PATCH default constants.
  - FB_ADDR_W = 12 and FB_FRAME_BYTES = 4096.
- One natural sub-module, fb_idle_watchdog: the timeout counter, instantiated only under FB_WRITER_TIMEOUT_EN.

Test Plan:
- Load: send 0x4C followed by 4096 bytes (value = index & 0xFF), rx_valid held high.
  - Required: 4096 wr_en pulses with addresses 0..4095 in order.
  - Required: frame_done on the last write; busy=0 afterwards.
  - Required: read-port word 0x0001 returns 16'h0203.
- Patch with wrap: send 0x50, 0x0F, 0xFE, 0x03, AA BB CC DD.
  - Required: writes at 0xFFE=AA, 0xFFF=BB, 0x000=CC, 0x001=DD.
  - Required: frame_done with the write at 0x001.
- Garbage and lock: in IDLE send 0x00, 0xFF, 0x41 → no wr_en, busy=0.
  - Then raise mem_lock partway through a patch for 20 cycles.
  - Required: rx_ready=0 and no writes during the lock; the burst resumes at the correct address after the lock drops.
- Latency: accept byte 0x5A at cycle N in L_DATA.
  - Required: wr_en=1 with wr_data=0x5A only in cycle N+1.
- Reset mid-patch: drop reset_n after 2 of 4 patch data bytes.
  - Required: all outputs return to 0 asynchronously; state=IDLE.
  - Required: a following 0x4C load starts at address 0.
- With FB_WRITER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 0x50, 0x00, then idle.
  - Required: err pulses exactly at 100 idle cycles, then busy=0.
  - Required: the next 0x4C is accepted as a command.

Source files
------------

// File: rtl/fb_writer_pkg.sv
// Shared types and defaults for the frame-buffer byte writer.
// The optional idle timeout is enabled by defining FB_WRITER_TIMEOUT_EN.
package fb_writer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      P_AHI,
      P_ALO,
      P_CNT,
      P_DATA,
      L_DATA
   } fb_state_e;

   localparam logic [7:0]  FB_CMD_LOAD       = 8'h4C;
   localparam logic [7:0]  FB_CMD_PATCH      = 8'h50;
   localparam int unsigned FB_ADDR_W         = 12;
   localparam int unsigned FB_FRAME_BYTES    = 4096;
   localparam int unsigned FB_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/fb_byte_writer_if.sv
// Stream-in / RAM-write-out bundle for fb_byte_writer.
// The slave modport is the writer's view; the master modport is the feeder/monitor view.
interface fb_byte_writer_if
   import fb_writer_pkg::*;
#(
   parameter int unsigned ADDR_W = FB_ADDR_W
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              mem_lock;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_en;
   logic              busy;
   logic              frame_done;
   logic              err;

   modport slave (
      input  rx_data, rx_valid, mem_lock,
      output rx_ready, wr_addr, wr_data, wr_en, busy, frame_done, err
   );

   modport master (
      output rx_data, rx_valid, mem_lock,
      input  rx_ready, wr_addr, wr_data, wr_en, busy, frame_done, err
   );
endinterface

// File: rtl/fb_idle_watchdog.sv
// Idle-cycle counter that flags a stalled command; only instantiated when
// FB_WRITER_TIMEOUT_EN is defined.
module fb_idle_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_run,
   output logic o_timeout
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   // Fires in the cycle that completes TIMEOUT_CYCLES idle cycles.
   assign o_timeout = i_run & ~i_clear & (r_count == LAST_COUNT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear || o_timeout) begin
         r_count <= '0;
      end else if (i_run) begin
         r_count <= r_count + 1'b1;
      end
   end
endmodule

// File: rtl/fb_byte_writer.sv
// Parses the UART byte stream (load / patch commands) and drives the frame-buffer
// RAM write port. Define FB_WRITER_TIMEOUT_EN to abort stalled commands.
module fb_byte_writer
   import fb_writer_pkg::*;
#(
   parameter int unsigned ADDR_W         = FB_ADDR_W,
   parameter int unsigned FRAME_BYTES    = FB_FRAME_BYTES,
   parameter logic [7:0]  CMD_LOAD       = FB_CMD_LOAD,
   parameter logic [7:0]  CMD_PATCH      = FB_CMD_PATCH,
   parameter int unsigned TIMEOUT_CYCLES = FB_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   fb_byte_writer_if.slave  bus
);
   localparam logic [ADDR_W:0] LAST_LOAD_IDX = (ADDR_W + 1)'(FRAME_BYTES - 1);

   if (FRAME_BYTES > (1 << ADDR_W) || FRAME_BYTES == 0 || TIMEOUT_CYCLES == 0
       || ADDR_W < 9 || ADDR_W > 16) begin : g_bad_param
      $error("fb_byte_writer: illegal parameter combination");
   end

   fb_state_e         r_state;
   fb_state_e         w_state_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_byte_cnt;
   logic [8:0]        r_remaining;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;
   logic              r_wr_en;
   logic              r_frame_done;
   logic              r_err;
   logic              w_accept;
   logic              w_in_data;
   logic              w_last;
   logic              w_timeout;

   assign bus.rx_ready   = reset_n & ~bus.mem_lock;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_data    = r_wr_data;
   assign bus.wr_en      = r_wr_en;
   assign bus.frame_done = r_frame_done;
   assign bus.err        = r_err;
   assign bus.busy       = (r_state != IDLE);

   assign w_accept  = bus.rx_valid & bus.rx_ready;
   assign w_in_data = (r_state == P_DATA) || (r_state == L_DATA);
   assign w_last    = (r_state == L_DATA) ? (r_byte_cnt == LAST_LOAD_IDX)
                                          : (r_remaining == 9'd1);

`ifdef FB_WRITER_TIMEOUT_EN
   // Clearing while in IDLE also covers the "clear on entry to IDLE" case.
   fb_idle_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clear   (w_accept | (r_state == IDLE)),
      .i_run     ((r_state != IDLE) & ~bus.mem_lock),
      .o_timeout (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_timeout) begin
         w_state_next = IDLE;
      end else if (w_accept) begin
         case (r_state)
            IDLE: begin
               if (bus.rx_data == CMD_LOAD) begin
                  w_state_next = L_DATA;
               end else if (bus.rx_data == CMD_PATCH) begin
                  w_state_next = P_AHI;
               end
            end
            P_AHI:          w_state_next = P_ALO;
            P_ALO:          w_state_next = P_CNT;
            P_CNT:          w_state_next = P_DATA;
            P_DATA, L_DATA: if (w_last) w_state_next = IDLE;
            default:        w_state_next = IDLE;
         endcase
      end
   end

   // Write outputs are registered: a byte accepted in cycle N is written in N+1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr       <= '0;
         r_byte_cnt   <= '0;
         r_remaining  <= '0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_wr_en      <= w_accept & w_in_data & ~w_timeout;
         r_frame_done <= w_accept & w_in_data & w_last & ~w_timeout;
         r_err        <= w_timeout;
         if (w_accept && !w_timeout) begin
            case (r_state)
               IDLE: begin
                  if (bus.rx_data == CMD_LOAD) begin
                     r_addr     <= '0;
                     r_byte_cnt <= '0;
                  end
               end
               P_AHI:  r_addr[ADDR_W-1:8] <= bus.rx_data[ADDR_W-9:0];
               P_ALO:  r_addr[7:0]        <= bus.rx_data;
               P_CNT:  r_remaining        <= {1'b0, bus.rx_data} + 9'd1;
               P_DATA, L_DATA: begin
                  r_wr_addr <= r_addr;
                  r_wr_data <= bus.rx_data;
                  r_addr    <= r_addr + 1'b1;
                  if (r_state == L_DATA) begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end else begin
                     r_remaining <= r_remaining - 9'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fb_byte_writer.sv
// Self-checking bench for fb_byte_writer: vector table plus directed multi-cycle
// sequences; the timeout sequence runs only when FB_WRITER_TIMEOUT_EN is defined.
module tb_fb_byte_writer;
   import fb_writer_pkg::*;

   typedef struct {
      logic [7:0]  d;
      logic        v;
      logic        l;
      logic        e_en;
      logic [11:0] e_addr;
      logic [7:0]  e_data;
      logic        e_busy;
      logic        e_fd;
   } vec_t;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;
   logic [7:0] ram [4096];
   vec_t vecs [14];

   fb_byte_writer_if #(.ADDR_W(12)) bus ();

   fb_byte_writer #(
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the dual-width RAM write side.
   always @(posedge clk) begin
      if (bus.wr_en === 1'b1) ram[bus.wr_addr] <= bus.wr_data;
   end

   function automatic logic [15:0] read_word(input int w);
      return {ram[2 * w], ram[2 * w + 1]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Drive one cycle of stimulus; returns just after the rising edge.
   task automatic cyc(input logic [7:0] d, input logic v, input logic l);
      @(negedge clk);
      bus.rx_data  = d;
      bus.rx_valid = v;
      bus.mem_lock = l;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.mem_lock = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int good;
      int bad;
      n_checks = 0;
      n_fail   = 0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.mem_lock = 1'b0;
      reset_n      = 1'b0;

      vecs[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{8'h41, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0};
      vecs[3]  = '{8'h50, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
      vecs[4]  = '{8'h0F, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
      vecs[5]  = '{8'hFE, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
      vecs[6]  = '{8'h03, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
      vecs[7]  = '{8'hAA, 1'b1, 1'b0, 1'b1, 12'hFFE, 8'hAA, 1'b1, 1'b0};
      vecs[8]  = '{8'h4C, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
      vecs[9]  = '{8'hBB, 1'b1, 1'b0, 1'b1, 12'hFFF, 8'hBB, 1'b1, 1'b0};
      vecs[10] = '{8'hCC, 1'b1, 1'b0, 1'b1, 12'h000, 8'hCC, 1'b1, 1'b0};
      vecs[11] = '{8'hDD, 1'b1, 1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
      vecs[12] = '{8'hDD, 1'b1, 1'b0, 1'b1, 12'h001, 8'hDD, 1'b0, 1'b1};
      vecs[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_en",   32'(bus.wr_en), 0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 0);
      chk("rst_wr_data", 32'(bus.wr_data), 0);
      chk("rst_busy",    32'(bus.busy), 0);
      chk("rst_fd",      32'(bus.frame_done), 0);
      chk("rst_err",     32'(bus.err), 0);
      chk("rst_rx_ready", 32'(bus.rx_ready), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Garbage bytes, then a wrapping patch with a gap and a one-cycle lock
      for (int i = 0; i < 14; i++) begin
         cyc(vecs[i].d, vecs[i].v, vecs[i].l);
         chk($sformatf("vec%0d_wr_en", i), 32'(bus.wr_en), 32'(vecs[i].e_en));
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
         chk($sformatf("vec%0d_fd", i), 32'(bus.frame_done), 32'(vecs[i].e_fd));
         chk($sformatf("vec%0d_rx_ready", i), 32'(bus.rx_ready), 32'(!vecs[i].l));
         if (vecs[i].e_en) begin
            chk($sformatf("vec%0d_wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_wr_data", i), 32'(bus.wr_data), 32'(vecs[i].e_data));
         end
      end
      chk("patch_word_7ff", 32'(read_word(12'h7FF)), 32'hAABB);
      chk("patch_word_000", 32'(read_word(0)), 32'hCCDD);

      // Full-frame load
      cyc(8'h4C, 1'b1, 1'b0);
      chk("load_cmd_wr_en", 32'(bus.wr_en), 0);
      chk("load_cmd_busy",  32'(bus.busy), 1);
      good = 0;
      for (int i = 0; i < 4096; i++) begin
         cyc(8'(i), 1'b1, 1'b0);
         if (bus.wr_en === 1'b1 && bus.wr_addr === 12'(i) && bus.wr_data === 8'(i)
             && bus.frame_done === (i == 4095))
            good++;
      end
      chk("load_writes_ok", 32'(good), 4096);
      chk("load_busy_after", 32'(bus.busy), 0);
      cyc(8'h00, 1'b0, 1'b0);
      chk("load_idle_wr_en", 32'(bus.wr_en), 0);
      chk("load_idle_fd",    32'(bus.frame_done), 0);
      chk("load_word_0001",  32'(read_word(1)), 32'h0203);
      chk("load_word_07ff",  32'(read_word(12'h7FF)), 32'hFEFF);

      // Patch paused by a 20-cycle lock
      cyc(8'h50, 1'b1, 1'b0);
      cyc(8'h07, 1'b1, 1'b0);
      cyc(8'hF0, 1'b1, 1'b0);
      cyc(8'h03, 1'b1, 1'b0);
      cyc(8'h71, 1'b1, 1'b0);
      chk("lockp_addr0", 32'(bus.wr_addr), 32'h7F0);
      cyc(8'h72, 1'b1, 1'b0);
      chk("lockp_addr1", 32'(bus.wr_addr), 32'h7F1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(8'h73, 1'b1, 1'b1);
         if (bus.rx_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b1) bad++;
      end
      chk("lockp_held_cycles_bad", 32'(bad), 0);
      cyc(8'h73, 1'b1, 1'b0);
      chk("lockp_resume_en",   32'(bus.wr_en), 1);
      chk("lockp_resume_addr", 32'(bus.wr_addr), 32'h7F2);
      chk("lockp_resume_data", 32'(bus.wr_data), 32'h73);
      chk("lockp_resume_fd",   32'(bus.frame_done), 0);
      cyc(8'h74, 1'b1, 1'b0);
      chk("lockp_last_addr", 32'(bus.wr_addr), 32'h7F3);
      chk("lockp_last_fd",   32'(bus.frame_done), 1);
      chk("lockp_last_busy", 32'(bus.busy), 0);

      // Asynchronous reset mid-patch, then load restarts at 0 with one-cycle latency
      cyc(8'h50, 1'b1, 1'b0);
      cyc(8'h02, 1'b1, 1'b0);
      cyc(8'h00, 1'b1, 1'b0);
      cyc(8'h03, 1'b1, 1'b0);
      cyc(8'hE1, 1'b1, 1'b0);
      cyc(8'hE2, 1'b1, 1'b0);
      chk("midrst_pre_wr_en", 32'(bus.wr_en), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_wr_en",    32'(bus.wr_en), 0);
      chk("midrst_wr_addr",  32'(bus.wr_addr), 0);
      chk("midrst_wr_data",  32'(bus.wr_data), 0);
      chk("midrst_busy",     32'(bus.busy), 0);
      chk("midrst_rx_ready", 32'(bus.rx_ready), 0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(8'h4C, 1'b1, 1'b0);
      chk("lat_cmd_wr_en", 32'(bus.wr_en), 0);
      chk("lat_cmd_busy",  32'(bus.busy), 1);
      cyc(8'h5A, 1'b1, 1'b0);
      chk("lat_n1_wr_en",   32'(bus.wr_en), 1);
      chk("lat_n1_wr_data", 32'(bus.wr_data), 32'h5A);
      chk("lat_n1_wr_addr", 32'(bus.wr_addr), 0);
      cyc(8'h00, 1'b0, 1'b0);
      chk("lat_n2_wr_en", 32'(bus.wr_en), 0);
      chk("lat_n2_busy",  32'(bus.busy), 1);
      do_reset();

`ifdef FB_WRITER_TIMEOUT_EN
      // Stalled patch aborts after 100 idle cycles
      cyc(8'h50, 1'b1, 1'b0);
      cyc(8'h00, 1'b1, 1'b0);
      bad = 0;
      for (int k = 1; k < 100; k++) begin
         cyc(8'h00, 1'b0, 1'b0);
         if (bus.err !== 1'b0 || bus.busy !== 1'b1) bad++;
      end
      chk("to_early_err_or_idle", 32'(bad), 0);
      cyc(8'h00, 1'b0, 1'b0);
      chk("to_err_pulse", 32'(bus.err), 1);
      chk("to_busy",      32'(bus.busy), 0);
      chk("to_wr_en",     32'(bus.wr_en), 0);
      chk("to_fd",        32'(bus.frame_done), 0);
      cyc(8'h00, 1'b0, 1'b0);
      chk("to_err_one_cycle", 32'(bus.err), 0);
      cyc(8'h4C, 1'b1, 1'b0);
      chk("to_next_cmd_busy", 32'(bus.busy), 1);
      cyc(8'h11, 1'b1, 1'b0);
      chk("to_next_addr", 32'(bus.wr_addr), 0);
      do_reset();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_time_limit actual=expired required=finished");
      $fatal(1, "time limit");
   end
endmodule
